// File: rtl/jt900h_busarb_if.sv
// Request/grant and RAM-pin bundle shared by the CPU memory controller, the micro-DMA
// engine and the external 16-bit RAM port arbiter.
interface jt900h_busarb_if;
    logic        cpu_req;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_we;
    logic        cpu_ok;

    logic        dma_req;
    logic [23:0] dma_addr;
    logic [15:0] dma_din;
    logic [1:0]  dma_we;
    logic        dma_ok;

    logic [15:0] dout;
    logic        dma_gnt;

    logic [23:0] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_we;
    logic [15:0] ram_dout;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_addr, cpu_din, cpu_we,
        input  dma_req, dma_addr, dma_din, dma_we,
        input  ram_dout,
        output cpu_ok, dma_ok, dout, dma_gnt,
        output ram_addr, ram_din, ram_we
    );

    // Requesters and RAM model side
    modport master (
        output cpu_req, cpu_addr, cpu_din, cpu_we,
        output dma_req, dma_addr, dma_din, dma_we,
        output ram_dout,
        input  cpu_ok, dma_ok, dout, dma_gnt,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/jt900h_busarb.sv
// External RAM port arbiter: DMA has priority, a streak limit guarantees the CPU a slot.
// Every access is address/data out, fixed read latency, then a one-cen-period ok pulse.
module jt900h_busarb #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned DMA_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    jt900h_busarb_if.slave  bus
);

    localparam logic [1:0] RdLat  = 2'(RD_LAT);
    localparam logic [3:0] DmaMax = 4'(DMA_MAX);

    typedef enum logic {StIdle, StAcc} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;      // 1 = DMA owns the current access
    logic [1:0]  lat_q, lat_d;
    logic [3:0]  streak_q, streak_d;
    logic [23:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_din_q, ram_din_d;
    logic [1:0]  ram_we_q, ram_we_d;
    logic        cpu_ok_q, cpu_ok_d;
    logic        dma_ok_q, dma_ok_d;
    logic [15:0] dout_q, dout_d;
    logic        cpu_wins;
    logic        acc_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (cen) begin
            state_q <= state_d;
        end
    end

    assign acc_done = (ram_we_q != 2'b00) || (lat_q == 2'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.cpu_req || bus.dma_req) state_d = StAcc;
            StAcc:  if (acc_done) state_d = StIdle;
        endcase
    end

    // CPU only beats a pending DMA request once the DMA streak hits its limit
    assign cpu_wins = bus.cpu_req && (!bus.dma_req || streak_q == DmaMax);

    always_comb begin
        owner_d    = owner_q;
        lat_d      = lat_q;
        streak_d   = streak_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = ram_we_q;
        cpu_ok_d   = cpu_ok_q;
        dma_ok_d   = dma_ok_q;
        dout_d     = dout_q;
        unique case (state_q)
            StIdle: begin
                cpu_ok_d = 1'b0;
                dma_ok_d = 1'b0;
                if (!bus.dma_req) streak_d = 4'd0;
                if (cpu_wins) begin
                    owner_d    = 1'b0;
                    streak_d   = 4'd0;
                    ram_addr_d = bus.cpu_addr;
                    ram_din_d  = bus.cpu_din;
                    ram_we_d   = bus.cpu_we;
                    lat_d      = RdLat;
                end else if (bus.dma_req) begin
                    owner_d    = 1'b1;
                    streak_d   = (streak_q == DmaMax) ? streak_q : streak_q + 4'd1;
                    ram_addr_d = bus.dma_addr;
                    ram_din_d  = bus.dma_din;
                    ram_we_d   = bus.dma_we;
                    lat_d      = RdLat;
                end
            end
            StAcc: begin
                if (ram_we_q != 2'b00) begin
                    ram_we_d = 2'b00;
                end else begin
                    lat_d = lat_q - 2'd1;
                    if (lat_q == 2'd1) dout_d = bus.ram_dout;
                end
                if (acc_done) begin
                    if (owner_q) dma_ok_d = 1'b1;
                    else         cpu_ok_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= 1'b0;
            lat_q      <= 2'd0;
            streak_q   <= 4'd0;
            ram_addr_q <= 24'd0;
            ram_din_q  <= 16'd0;
            ram_we_q   <= 2'b00;
            cpu_ok_q   <= 1'b0;
            dma_ok_q   <= 1'b0;
            dout_q     <= 16'd0;
        end else if (cen) begin
            owner_q    <= owner_d;
            lat_q      <= lat_d;
            streak_q   <= streak_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            cpu_ok_q   <= cpu_ok_d;
            dma_ok_q   <= dma_ok_d;
            dout_q     <= dout_d;
        end
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.cpu_ok   = cpu_ok_q;
    assign bus.dma_ok   = dma_ok_q;
    assign bus.dout     = dout_q;
    assign bus.dma_gnt  = (state_q == StAcc) && owner_q;

    a_ok_excl: assert property (@(posedge clk) disable iff (rst) !(cpu_ok_q && dma_ok_q));
    a_we_acc:  assert property (@(posedge clk) disable iff (rst)
                                (ram_we_q != 2'b00) |-> (state_q == StAcc));

endmodule

// File: tb/tb_jt900h_busarb.sv
// Directed bench for jt900h_busarb: one instance at RD_LAT=1 with cen always high, and one at
// RD_LAT=3 driven with a 1-in-3 clock enable.
module tb_jt900h_busarb;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic cen  = 1'b1;
    logic cen3 = 1'b0;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    jt900h_busarb_if b1 ();
    jt900h_busarb_if b3 ();

    jt900h_busarb #(.RD_LAT(1), .DMA_MAX(4)) dut (.clk(clk), .rst(rst), .cen(cen), .bus(b1));
    jt900h_busarb #(.RD_LAT(3), .DMA_MAX(4)) dut3 (.clk(clk), .rst(rst), .cen(cen3), .bus(b3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic c);
        cen3 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        b1.cpu_req = 0; b1.cpu_addr = 0; b1.cpu_din = 0; b1.cpu_we = 0;
        b1.dma_req = 0; b1.dma_addr = 0; b1.dma_din = 0; b1.dma_we = 0; b1.ram_dout = 0;
        b3.cpu_req = 0; b3.cpu_addr = 0; b3.cpu_din = 0; b3.cpu_we = 0;
        b3.dma_req = 0; b3.dma_addr = 0; b3.dma_din = 0; b3.dma_we = 0; b3.ram_dout = 0;
        rst = 1'b1;
        tick; tick;
        total++; if (b1.ram_addr !== 24'h0) $display("FAIL rst_addr got %h want 0", b1.ram_addr);
                 else passed++;
        total++; if (b1.ram_din !== 16'h0) $display("FAIL rst_din got %h want 0", b1.ram_din);
                 else passed++;
        total++; if (b1.ram_we !== 2'b00) $display("FAIL rst_we got %b want 00", b1.ram_we);
                 else passed++;
        total++; if ({b1.cpu_ok, b1.dma_ok, b1.dma_gnt} !== 3'b000)
                     $display("FAIL rst_flags got %b want 000", {b1.cpu_ok, b1.dma_ok, b1.dma_gnt});
                 else passed++;
        total++; if (b1.dout !== 16'h0) $display("FAIL rst_dout got %h want 0", b1.dout);
                 else passed++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_cpu_read;
        b1.cpu_req = 1; b1.cpu_addr = 24'h000100; b1.cpu_we = 2'b00; b1.ram_dout = 16'hBEEF;
        tick;
        total++; if (b1.ram_addr !== 24'h000100)
                     $display("FAIL rd_addr got %h want 000100", b1.ram_addr);
                 else passed++;
        total++; if ({b1.cpu_ok, b1.ram_we, b1.dma_gnt} !== 4'b0000)
                     $display("FAIL rd_grant got %b want 0000", {b1.cpu_ok, b1.ram_we, b1.dma_gnt});
                 else passed++;
        tick;
        total++; if (b1.cpu_ok !== 1'b1) $display("FAIL rd_ok got %b want 1", b1.cpu_ok);
                 else passed++;
        total++; if (b1.dout !== 16'hBEEF) $display("FAIL rd_dout got %h want beef", b1.dout);
                 else passed++;
        b1.cpu_req = 0;
        tick;
        total++; if (b1.cpu_ok !== 1'b0) $display("FAIL rd_okclr got %b want 0", b1.cpu_ok);
                 else passed++;
        // Request dropped inside the ok period: the bus must stay quiet.
        tick; tick; tick;
        total++; if ({b1.cpu_ok, b1.dma_ok, b1.ram_we, b1.dma_gnt} !== 5'b0)
                     $display("FAIL rd_quiet got %b want 00000",
                              {b1.cpu_ok, b1.dma_ok, b1.ram_we, b1.dma_gnt});
                 else passed++;
        total++; if (b1.ram_addr !== 24'h000100)
                     $display("FAIL rd_hold got %h want 000100", b1.ram_addr);
                 else passed++;
    endtask

    task automatic test_dma_write;
        b1.dma_req = 1; b1.dma_addr = 24'h002000; b1.dma_din = 16'h1234; b1.dma_we = 2'b11;
        tick;
        total++; if ({b1.ram_addr, b1.ram_din, b1.ram_we} !== {24'h002000, 16'h1234, 2'b11})
                     $display("FAIL wr_bus got %h %h %b want 002000 1234 11",
                              b1.ram_addr, b1.ram_din, b1.ram_we);
                 else passed++;
        total++; if ({b1.dma_gnt, b1.dma_ok} !== 2'b10)
                     $display("FAIL wr_gnt got %b want 10", {b1.dma_gnt, b1.dma_ok});
                 else passed++;
        tick;
        total++; if ({b1.ram_we, b1.dma_gnt, b1.dma_ok, b1.cpu_ok} !== 5'b00010)
                     $display("FAIL wr_done got %b want 00010",
                              {b1.ram_we, b1.dma_gnt, b1.dma_ok, b1.cpu_ok});
                 else passed++;
        b1.dma_req = 0;
        tick;
        total++; if (b1.dma_ok !== 1'b0) $display("FAIL wr_okclr got %b want 0", b1.dma_ok);
                 else passed++;
    endtask

    task automatic test_arbitration;
        string order;
        logic  exp_d;
        order = "DDDDCDDDDC";
        b1.cpu_req = 1; b1.cpu_addr = 24'h111110; b1.cpu_we = 2'b00;
        b1.dma_req = 1; b1.dma_addr = 24'h222220; b1.dma_we = 2'b00;
        for (int k = 0; k < 10; k++) begin
            exp_d = (order[k] == "D");
            tick;
            total++; if (b1.ram_addr !== (exp_d ? 24'h222220 : 24'h111110))
                         $display("FAIL arb_grant%0d got %h want %s", k, b1.ram_addr,
                                  exp_d ? "222220" : "111110");
                     else passed++;
            tick;
            total++; if ({b1.dma_ok, b1.cpu_ok} !== (exp_d ? 2'b10 : 2'b01))
                         $display("FAIL arb_ok%0d got %b want %b", k, {b1.dma_ok, b1.cpu_ok},
                                  exp_d ? 2'b10 : 2'b01);
                     else passed++;
        end
        b1.cpu_req = 0; b1.dma_req = 0;
        tick;
    endtask

    task automatic test_reset_mid_write;
        b1.dma_req = 1; b1.dma_addr = 24'h003000; b1.dma_din = 16'h5555; b1.dma_we = 2'b11;
        tick;
        total++; if (b1.ram_we !== 2'b11) $display("FAIL mrst_pre got %b want 11", b1.ram_we);
                 else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({b1.ram_we, b1.dma_gnt, b1.dma_ok, b1.cpu_ok} !== 5'b0)
                     $display("FAIL mrst_async got %b want 00000",
                              {b1.ram_we, b1.dma_gnt, b1.dma_ok, b1.cpu_ok});
                 else passed++;
        total++; if ({b1.ram_addr, b1.ram_din, b1.dout} !== 56'h0)
                     $display("FAIL mrst_bus got %h %h %h want 0", b1.ram_addr, b1.ram_din,
                              b1.dout);
                 else passed++;
        tick;
        total++; if (b1.dma_ok !== 1'b0) $display("FAIL mrst_nook got %b want 0", b1.dma_ok);
                 else passed++;
        rst = 1'b0;
        tick;
        total++; if ({b1.ram_addr, b1.ram_we, b1.dma_gnt} !== {24'h003000, 2'b11, 1'b1})
                     $display("FAIL mrst_regrant got %h %b %b want 003000 11 1",
                              b1.ram_addr, b1.ram_we, b1.dma_gnt);
                 else passed++;
        tick;
        total++; if (b1.dma_ok !== 1'b1) $display("FAIL mrst_ok got %b want 1", b1.dma_ok);
                 else passed++;
        b1.dma_req = 0;
        tick;
    endtask

    task automatic test_slow_cen;
        int oks;
        b3.cpu_req = 1; b3.cpu_addr = 24'h004444; b3.cpu_we = 2'b00; b3.ram_dout = 16'hA5A5;
        step3(1);
        total++; if (b3.ram_addr !== 24'h004444)
                     $display("FAIL slow_addr got %h want 004444", b3.ram_addr);
                 else passed++;
        step3(0); step3(0);
        for (int e = 1; e <= 2; e++) begin
            step3(1); step3(0); step3(0);
            total++; if (b3.cpu_ok !== 1'b0)
                         $display("FAIL slow_early%0d got %b want 0", e, b3.cpu_ok);
                     else passed++;
        end
        step3(1);
        total++; if ({b3.cpu_ok, b3.dout} !== {1'b1, 16'hA5A5})
                     $display("FAIL slow_done got %b %h want 1 a5a5", b3.cpu_ok, b3.dout);
                 else passed++;
        b3.cpu_req = 0;
        step3(0);
        total++; if (b3.cpu_ok !== 1'b1) $display("FAIL slow_hold1 got %b want 1", b3.cpu_ok);
                 else passed++;
        step3(0);
        total++; if (b3.cpu_ok !== 1'b1) $display("FAIL slow_hold2 got %b want 1", b3.cpu_ok);
                 else passed++;
        step3(1);
        total++; if (b3.cpu_ok !== 1'b0) $display("FAIL slow_clr got %b want 0", b3.cpu_ok);
                 else passed++;
        oks = 0;
        repeat (12) begin
            step3(1); if (b3.cpu_ok || b3.dma_ok) oks++;
            step3(0); step3(0);
        end
        total++; if (oks !== 0) $display("FAIL slow_double got %0d want 0", oks);
                 else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_cpu_read;
        test_dma_write;
        test_arbitration;
        test_reset_mid_write;
        test_slow_cen;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
